// File: rtl/multi_voice_osc_pkg.sv
// Shared constants for the time-multiplexed oscillator bank.
// Contents: config addresses, control-bit positions, noise LFSR definition and FSM states.
package osc_pkg;

    localparam logic [1:0] CFG_FREQ = 2'd0;
    localparam logic [1:0] CFG_PW   = 2'd1;
    localparam logic [1:0] CFG_CTRL = 2'd2;
    localparam logic [1:0] CFG_CLR  = 2'd3;

    localparam int CTRL_GATE  = 0;
    localparam int CTRL_TEST  = 1;
    localparam int CTRL_SYNC  = 2;
    localparam int CTRL_RING  = 3;
    localparam int CTRL_TRI   = 4;
    localparam int CTRL_SAW   = 5;
    localparam int CTRL_PULSE = 6;
    localparam int CTRL_NOISE = 7;

    localparam int               LFSR_BITS     = 23;
    localparam logic [22:0]      LFSR_SEED     = 23'h7FFFF8;
    localparam int               LFSR_TAP_HI   = 22;
    localparam int               LFSR_TAP_LO   = 17;
    localparam int               NOISE_CLK_BIT = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [LFSR_BITS-1:0] lfsr_next(input logic [LFSR_BITS-1:0] s);
        return {s[LFSR_BITS-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/multi_voice_osc_voice_waveform.sv
// Shared combinational waveform stage: one voice's updated phase -> signed sample.
// Only the phase bits the waveforms actually use are passed in.
module voice_waveform
    import osc_pkg::*;
#(
    parameter int OUT_BITS = 12,
    parameter int PW_BITS  = 12
) (
    input  logic [OUT_BITS:0]          phase,
    input  logic [PW_BITS-1:0]         pw,
    input  logic [7:3]                 ctrl,
    input  logic [OUT_BITS-1:0]        noise,
    input  logic                       src_msb,
    output logic signed [OUT_BITS-1:0] sample
);
    localparam int CMP_BITS = (OUT_BITS > PW_BITS) ? OUT_BITS : PW_BITS;

    logic [OUT_BITS-1:0] saw;
    logic [OUT_BITS-1:0] tri_w;
    logic [OUT_BITS-1:0] pulse;
    logic [OUT_BITS-1:0] combined;
    logic                tri_invert;

    always_comb begin
        saw        = phase[OUT_BITS -: OUT_BITS];
        tri_invert = phase[OUT_BITS] ^ (ctrl[CTRL_RING] & src_msb);
        tri_w      = tri_invert ? ~phase[OUT_BITS-1:0] : phase[OUT_BITS-1:0];
        pulse      = (CMP_BITS'(saw) >= CMP_BITS'(pw)) ? '1 : '0;

        combined = '1;
        if (ctrl[CTRL_TRI])   combined = combined & tri_w;
        if (ctrl[CTRL_SAW])   combined = combined & saw;
        if (ctrl[CTRL_PULSE]) combined = combined & pulse;
        if (ctrl[CTRL_NOISE]) combined = combined & noise;
        if (ctrl[7:4] == 4'b0000) combined = '0;

        // offset-binary to two's complement
        sample = signed'(combined ^ {1'b1, {(OUT_BITS-1){1'b0}}});
    end

endmodule

// File: rtl/multi_voice_osc.sv
// Bank of phase-accumulator voices sharing one waveform datapath, one voice per clock,
// summed into a signed sample per sample_tick.
//   state | meaning
//   IDLE  | waiting for sample_tick, config port open
//   RUN   | processing voice[idx], accumulating frame sum
//   DONE  | publish mix_out, pulse mix_valid
module multi_voice_osc
    import osc_pkg::*;
#(
    parameter int  VOICES           = 3,
    parameter int  FREQ_BITS        = 16,
    parameter int  PULSEWIDTH_BITS  = 12,
    parameter int  OUTPUT_BITS      = 12,
    parameter int  ACCUMULATOR_BITS = 24,
    localparam int MIX_BITS         = OUTPUT_BITS + $clog2(VOICES),
    localparam int VOICE_BITS       = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                       main_clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [VOICE_BITS-1:0]      cfg_voice,
    input  logic [1:0]                 cfg_addr,
    input  logic [15:0]                cfg_wdata,
    output logic signed [MIX_BITS-1:0] mix_out,
    output logic                       mix_valid,
    output logic [VOICES-1:0]          voice_msb,
    output logic                       overrun
);
    localparam int                    A    = ACCUMULATOR_BITS;
    localparam int                    W    = OUTPUT_BITS;
    localparam logic [VOICE_BITS-1:0] LAST = VOICE_BITS'(VOICES - 1);

    state_t                      state;
    logic [VOICE_BITS-1:0]       idx;
    logic [VOICE_BITS-1:0]       src;
    logic [A-1:0]                acc   [VOICES];
    logic [FREQ_BITS-1:0]        freq  [VOICES];
    logic [PULSEWIDTH_BITS-1:0]  pw    [VOICES];
    logic [7:0]                  ctrl  [VOICES];
    logic [LFSR_BITS-1:0]        lfsr  [VOICES];
    logic [VOICES-1:0]           msb_rose;
    logic signed [MIX_BITS-1:0]  sum;
    logic [A-1:0]                new_acc;
    logic [7:0]                  cur_ctrl;
    logic signed [W-1:0]         sample;
    logic                        cfg_write;

    assign cfg_ready = (state == ST_IDLE);
    assign cfg_write = cfg_valid & cfg_ready;
    assign src       = (idx == '0) ? LAST : idx - VOICE_BITS'(1);
    assign cur_ctrl  = ctrl[idx];

    always_comb begin
        new_acc = acc[idx] + A'(freq[idx]);
        if (cur_ctrl[CTRL_TEST] || (cur_ctrl[CTRL_SYNC] && msb_rose[src]))
            new_acc = '0;
    end

    always_comb begin
        voice_msb = '0;
        for (int v = 0; v < VOICES; v++)
            voice_msb[v] = acc[v][A-1];
    end

    voice_waveform #(
        .OUT_BITS (W),
        .PW_BITS  (PULSEWIDTH_BITS)
    ) u_wave (
        .phase   (new_acc[A-1 -: W+1]),
        .pw      (pw[idx]),
        .ctrl    (cur_ctrl[7:3]),
        .noise   (lfsr[idx][LFSR_BITS-1 -: W]),
        .src_msb (acc[src][A-1]),
        .sample  (sample)
    );

    always_ff @(posedge main_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            sum       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
            msb_rose  <= '0;
            for (int v = 0; v < VOICES; v++) begin
                acc[v]  <= '0;
                freq[v] <= '0;
                pw[v]   <= '0;
                ctrl[v] <= '0;
                lfsr[v] <= LFSR_SEED;
            end
        end else begin
            mix_valid <= 1'b0;
            if (cfg_write) begin
                if (cfg_addr == CFG_CLR)
                    overrun <= 1'b0;
                else if (int'(cfg_voice) < VOICES) begin
                    case (cfg_addr)
                        CFG_FREQ: freq[cfg_voice] <= FREQ_BITS'(cfg_wdata);
                        CFG_PW:   pw[cfg_voice]   <= PULSEWIDTH_BITS'(cfg_wdata);
                        default:  ctrl[cfg_voice] <= cfg_wdata[7:0];
                    endcase
                end
            end
            if (sample_tick && state != ST_IDLE)
                overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (sample_tick) begin
                        state <= ST_RUN;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end
                ST_RUN: begin
                    acc[idx]      <= new_acc;
                    msb_rose[idx] <= ~acc[idx][A-1] & new_acc[A-1];
                    if (cur_ctrl[CTRL_TEST])
                        lfsr[idx] <= LFSR_SEED;
                    else if (~acc[idx][NOISE_CLK_BIT] & new_acc[NOISE_CLK_BIT])
                        lfsr[idx] <= lfsr_next(lfsr[idx]);
                    if (cur_ctrl[CTRL_GATE])
                        sum <= sum + MIX_BITS'(sample);
                    if (idx == LAST)
                        state <= ST_DONE;
                    else
                        idx <= idx + VOICE_BITS'(1);
                end
                ST_DONE: begin
                    mix_out   <= sum;
                    mix_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_voice_osc.sv
// Directed bench for multi_voice_osc with default parameters (3 voices, 14-bit mix).
// Expected samples are hand-computed from accumulator arithmetic.
module tb_multi_voice_osc;
    logic               main_clk;
    logic               reset_n;
    logic               sample_tick;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_voice;
    logic [1:0]         cfg_addr;
    logic [15:0]        cfg_wdata;
    logic signed [13:0] mix_out;
    logic               mix_valid;
    logic [2:0]         voice_msb;
    logic               overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    multi_voice_osc dut (
        .main_clk    (main_clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_voice   (cfg_voice),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .mix_out     (mix_out),
        .mix_valid   (mix_valid),
        .voice_msb   (voice_msb),
        .overrun     (overrun)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic cfg_wr(input logic [1:0] voice, input logic [1:0] addr, input logic [15:0] data);
        cfg_valid = 1'b1;
        cfg_voice = voice;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge main_clk);
        cfg_valid = 1'b0;
    endtask

    // Tick on the next edge, wait for mix_valid, then step past it so IDLE is reached.
    task automatic frame();
        int lat;
        sample_tick = 1'b1;
        @(negedge main_clk);
        sample_tick = 1'b0;
        cfg_valid   = 1'b0;
        lat = 0;
        while (mix_valid !== 1'b1 && lat < 20) begin
            @(negedge main_clk);
            lat++;
        end
        check("mix_latency", lat, 4);
        @(negedge main_clk);
        check("mix_valid_width", mix_valid, 1'b0);
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        @(negedge main_clk);
        @(negedge main_clk);
        reset_n = 1'b1;
        @(negedge main_clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        cfg_valid   = 1'b0;
        cfg_voice   = 2'd0;
        cfg_addr    = 2'd0;
        cfg_wdata   = 16'h0;
        repeat (3) @(negedge main_clk);
        reset_n = 1'b1;
        @(negedge main_clk);

        // reset state
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_voice_msb", voice_msb, 3'b000);
        frame();
        check("all_ungated", mix_out, 0);

        // saw
        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_wr(2'd0, 2'd2, 16'h0021);
        frame();
        check("saw_tick1", mix_out, -2047);
        for (int i = 0; i < 15; i++) frame();
        check("saw_tick16", mix_out, -2032);

        // triangle, ctrl written in the same cycle as the tick
        reset_dut();
        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_valid = 1'b1; cfg_voice = 2'd0; cfg_addr = 2'd2; cfg_wdata = 16'h0011;
        frame();
        check("tri_cfg_same_cycle", mix_out, -2046);

        // noise, waveform AND, two-voice mix, no waveform
        reset_dut();
        cfg_wr(2'd0, 2'd2, 16'h0081);
        frame();
        check("noise_seed", mix_out, 2047);
        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_wr(2'd0, 2'd2, 16'h00A1);
        frame();
        check("saw_and_noise", mix_out, -2047);
        cfg_wr(2'd1, 2'd2, 16'h0081);
        frame();
        check("two_voice_mix", mix_out, 1);
        cfg_wr(2'd0, 2'd2, 16'h0001);
        cfg_wr(2'd1, 2'd2, 16'h0000);
        frame();
        check("gated_no_wave", mix_out, -2048);

        // pulse threshold boundary: top bits 0x008 < 0x010, then 0x010 >= 0x010
        reset_dut();
        cfg_wr(2'd0, 2'd0, 16'h8000);
        cfg_wr(2'd0, 2'd1, 16'h0010);
        cfg_wr(2'd0, 2'd2, 16'h0041);
        frame();
        check("pulse_below_pw", mix_out, -2048);
        frame();
        check("pulse_at_pw", mix_out, 2047);

        // hard sync: voice0 MSB rises on tick 256, resetting voice1 in the same frame
        reset_dut();
        cfg_wr(2'd0, 2'd0, 16'h8000);
        cfg_wr(2'd1, 2'd0, 16'h1000);
        cfg_wr(2'd1, 2'd2, 16'h0025);
        for (int i = 0; i < 255; i++) frame();
        check("sync_before", mix_out, -1793);
        check("msb_before", voice_msb, 3'b000);
        frame();
        check("sync_reset", mix_out, -2048);
        check("msb_after", voice_msb, 3'b001);
        frame();
        check("sync_resume", mix_out, -2047);
        cfg_wr(2'd1, 2'd2, 16'h0027);
        frame();
        check("test_hold1", mix_out, -2048);
        frame();
        check("test_hold2", mix_out, -2048);

        // overrun
        reset_dut();
        sample_tick = 1'b1;
        @(negedge main_clk);
        sample_tick = 1'b0;
        @(negedge main_clk);
        check("cfg_ready_busy", cfg_ready, 1'b0);
        sample_tick = 1'b1;
        @(negedge main_clk);
        sample_tick = 1'b0;
        check("overrun_set", overrun, 1'b1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (mix_valid === 1'b1) pulses++;
            @(negedge main_clk);
        end
        check("single_mix_valid", pulses, 1);
        check("overrun_sticky", overrun, 1'b1);
        cfg_wr(2'd3, 2'd2, 16'h0021);
        frame();
        check("bad_voice_ignored", mix_out, 0);
        check("overrun_kept", overrun, 1'b1);
        cfg_wr(2'd3, 2'd3, 16'h0000);
        check("overrun_clear", overrun, 1'b0);

        // reset mid-frame
        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_wr(2'd0, 2'd2, 16'h0021);
        sample_tick = 1'b1;
        @(negedge main_clk);
        sample_tick = 1'b0;
        @(negedge main_clk);
        @(negedge main_clk);
        reset_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) reset_n = 1'b1;
            if (mix_valid === 1'b1) pulses++;
            @(negedge main_clk);
        end
        check("midrst_no_valid", pulses, 0);
        check("midrst_mix_out", mix_out, 0);
        check("midrst_cfg_ready", cfg_ready, 1'b1);
        check("midrst_overrun", overrun, 1'b0);
        check("midrst_voice_msb", voice_msb, 3'b000);
        frame();
        check("midrst_ctrl_cleared", mix_out, 0);
        cfg_wr(2'd0, 2'd0, 16'h1000);
        cfg_wr(2'd0, 2'd2, 16'h0021);
        frame();
        check("midrst_acc_cleared", mix_out, -2047);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
